serial_tx_sched: RTL



---
 rtl/serial_tx_pkg.sv | 26 ++
 rtl/serial_tx_sched_rr_arb4.sv | 41 ++++
 rtl/serial_tx_sched.sv | 138 +++++++++++++
 3 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial transmitter front-end scheduler.
// Optional partial-frame flush is compiled in with TX_SCHED_FLUSH_EN.
package serial_tx_pkg;

  localparam int NSLOT  = 4;
  localparam int SLOT_W = 2;

  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic [1:0] {
    S_FILL,
    S_PAD,
    S_XMIT,
    S_WAIT
  } state_t;

  localparam logic [3:0] PAD_WORD_DEF = 4'b0000;

  function automatic logic [NSLOT-1:0] slot_onehot(input slot_t s);
    logic [NSLOT-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/serial_tx_sched_rr_arb4.sv
// Four-way round-robin arbiter: combinational one-hot grant,
// priority pointer advances past the winner on every grant.
module rr_arb4
  import serial_tx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NSLOT-1:0] req,
  output logic [NSLOT-1:0] gnt,
  output slot_t            gnt_idx
);

  slot_t ptr_q;
  slot_t ptr_d;
  logic  found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NSLOT; k++) begin
      if (en && !found && req[ptr_q + slot_t'(k)]) begin
        gnt[ptr_q + slot_t'(k)] = 1'b1;
        gnt_idx                 = ptr_q + slot_t'(k);
        found                   = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) ptr_d = gnt_idx + slot_t'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/serial_tx_sched.sv
// Frame scheduler in front of the 4-slot parallel-to-serial transmitter.
// Define TX_SCHED_FLUSH_EN to pad and send partial frames after IDLE_TO idle cycles.
module serial_tx_sched
  import serial_tx_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter int               IDLE_TO  = 16,
  parameter logic [WIDTH-1:0] PAD_WORD = WIDTH'(PAD_WORD_DEF)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [NSLOT-1:0]       req,
  input  logic [NSLOT*WIDTH-1:0] din,
  output logic [NSLOT-1:0]       gnt,
  output logic [NSLOT-1:0]       ld,
  output logic [WIDTH-1:0]       ld_data,
  output logic                   transmit,
  input  logic                   sent_n,
  output logic                   busy,
  output logic [7:0]             frames
);

  if (IDLE_TO < 1 || IDLE_TO > 255) begin : g_bad_idle_to
    $error("IDLE_TO out of range");
  end

  state_t           state_q, state_d;
  slot_t            slot_q, slot_d;
  logic [NSLOT-1:0] ld_q, ld_d;
  logic [WIDTH-1:0] ld_data_q, ld_data_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [7:0]       frames_q, frames_d;
  slot_t            gnt_idx;
  logic             arb_en;

`ifdef TX_SCHED_FLUSH_EN
  logic [7:0] idle_q, idle_d;
`endif

  // Grants are gated by reset so nothing is accepted while clr is high.
  assign arb_en = (state_q == S_FILL) && !clr;

  rr_arb4 u_arb (
    .clk     (clk),
    .rst     (clr),
    .en      (arb_en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    ld_d      = '0;
    ld_data_d = '0;
    tx_d      = 1'b0;
    frames_d  = frames_q;
`ifdef TX_SCHED_FLUSH_EN
    idle_d    = idle_q;
`endif
    unique case (state_q)
      S_FILL: begin
        if (|gnt) begin
          ld_d      = slot_onehot(slot_q);
          ld_data_d = din[WIDTH*gnt_idx +: WIDTH];
          slot_d    = slot_q + slot_t'(1);
`ifdef TX_SCHED_FLUSH_EN
          idle_d    = '0;
`endif
          if (slot_q == slot_t'(NSLOT-1)) state_d = S_XMIT;
        end
`ifdef TX_SCHED_FLUSH_EN
        else if (slot_q != '0) begin
          if ({1'b0, idle_q} + 9'd1 >= 9'(IDLE_TO)) begin
            idle_d  = '0;
            state_d = S_PAD;
          end else begin
            idle_d = idle_q + 8'd1;
          end
        end
`endif
      end
      S_PAD: begin
        ld_d      = slot_onehot(slot_q);
        ld_data_d = PAD_WORD;
        slot_d    = slot_q + slot_t'(1);
        if (slot_q == slot_t'(NSLOT-1)) state_d = S_XMIT;
      end
      S_XMIT: begin
        state_d  = S_WAIT;
        tx_d     = 1'b1;
        frames_d = frames_q + 8'd1;
      end
      S_WAIT: begin
        // The cycle carrying transmit never releases the frame.
        if (!tx_q && !sent_n) state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
    busy_d = (state_d == S_XMIT) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_FILL;
      slot_q    <= '0;
      ld_q      <= '0;
      ld_data_q <= '0;
      tx_q      <= 1'b0;
      busy_q    <= 1'b0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      ld_q      <= ld_d;
      ld_data_q <= ld_data_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      frames_q  <= frames_d;
    end
  end

`ifdef TX_SCHED_FLUSH_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`endif

  assign ld       = ld_q;
  assign ld_data  = ld_data_q;
  assign transmit = tx_q;
  assign busy     = busy_q;
  assign frames   = frames_q;

endmodule
